logic_op_core: RTL and testbench

LOGIC_OP_CORE -- requirements
Module: logic_op_core

---
 rtl/logic_op_pkg.sv | 28 ++
 rtl/logic_op_fifo.sv | 69 ++++++
 rtl/logic_op_core.sv | 98 +++++++++
 tb/tb_logic_op_core.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op core: op encoding, default sizes, FIFO entry layout.
// Optional parity bit per entry is enabled with macro LOGIC_OP_PARITY_EN.
package logic_op_pkg;

   localparam int unsigned DATA_W_DEF     = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned OP_W           = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_ANDN = 3'd7
   } op_e;

   typedef struct packed {
      op_e                   op;
      logic [DATA_W_DEF-1:0] data;
`ifdef LOGIC_OP_PARITY_EN
      logic                  par;
`endif
   } res_entry_t;

endpackage

// File: rtl/logic_op_fifo.sv
// Show-ahead result FIFO with drop-on-full overflow detection and sticky error flag.
module logic_op_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     err_clr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   cnt,
   output logic                     ovf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_nxt;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign full    = (cnt == CNT_W'(DEPTH));
   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   always_comb begin
      cnt_nxt = cnt;
      if (push_ok && !pop_ok) begin
         cnt_nxt = cnt + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         valid  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt   <= cnt_nxt;
         valid <= (cnt_nxt != '0);
         // New overflow wins over a coincident clear.
         ovf   <= (push & full & ~pop_ok) | (ovf & ~err_clr);
      end
   end

endmodule

// File: rtl/logic_op_core.sv
// Two-stage bitwise logic unit feeding a show-ahead result FIFO.
// Macro LOGIC_OP_PARITY_EN adds a stored per-entry parity output out_par.
module logic_op_core
   import logic_op_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             data1,
   input  logic [DATA_W-1:0]             data2,
   input  logic                          data_en,
   input  logic [2:0]                    op_sel,
   output logic [DATA_W-1:0]             out_data,
   output logic [2:0]                    out_op,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          ovf_err,
`ifdef LOGIC_OP_PARITY_EN
   output logic                          out_par,
`endif
   input  logic                          err_clr
);

`ifdef LOGIC_OP_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned ENTRY_W = OP_W + DATA_W + PAR_W;

   logic               s1_vld;
   logic [DATA_W-1:0]  s1_a;
   logic [DATA_W-1:0]  s1_b;
   op_e                s1_op;
   logic [DATA_W-1:0]  res;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;

   // Operand capture stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_op  <= OP_AND;
      end else begin
         s1_vld <= data_en;
         if (data_en) begin
            s1_a  <= data1;
            s1_b  <= data2;
            s1_op <= op_e'(op_sel);
         end
      end
   end

   always_comb begin
      res = '0;
      case (s1_op)
         OP_AND:  res = s1_a & s1_b;
         OP_OR:   res = s1_a | s1_b;
         OP_XOR:  res = s1_a ^ s1_b;
         OP_NAND: res = ~(s1_a & s1_b);
         OP_NOR:  res = ~(s1_a | s1_b);
         OP_XNOR: res = ~(s1_a ^ s1_b);
         OP_NOT:  res = ~s1_a;
         OP_ANDN: res = s1_a & ~s1_b;
      endcase
   end

`ifdef LOGIC_OP_PARITY_EN
   assign wr_entry = {s1_op, res, ^res};
   assign out_par  = rd_entry[0];
`else
   assign wr_entry = {s1_op, res};
`endif
   assign out_op   = rd_entry[ENTRY_W-1 -: OP_W];
   assign out_data = rd_entry[PAR_W +: DATA_W];

   logic_op_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (s1_vld),
      .pop     (out_ready),
      .err_clr (err_clr),
      .wdata   (wr_entry),
      .rdata   (rd_entry),
      .valid   (out_valid),
      .cnt     (fifo_cnt),
      .ovf     (ovf_err)
   );

endmodule

// File: tb/tb_logic_op_core.sv
// Self-checking bench for logic_op_core: vector table, scoreboard model, corner sequences.
module tb_logic_op_core;
   import logic_op_pkg::*;

   localparam int unsigned DW    = DATA_W_DEF;
   localparam int unsigned DEPTH = FIFO_DEPTH_DEF;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] data1, data2;
   logic          data_en;
   logic [2:0]    op_sel;
   logic [DW-1:0] out_data;
   logic [2:0]    out_op;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] fifo_cnt;
   logic          ovf_err;
   logic          err_clr;
`ifdef LOGIC_OP_PARITY_EN
   logic          out_par;
`endif

   logic_op_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data1     (data1),
      .data2     (data2),
      .data_en   (data_en),
      .op_sel    (op_sel),
      .out_data  (out_data),
      .out_op    (out_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fifo_cnt  (fifo_cnt),
      .ovf_err   (ovf_err),
`ifdef LOGIC_OP_PARITY_EN
      .out_par   (out_par),
`endif
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [2:0]    op;
      logic [DW-1:0] exp;
   } vec_t;

   res_entry_t    exp_in[$];
   res_entry_t    model_q[$];
   res_entry_t    m_s1;
   bit            m_s1_vld = 1'b0;
   bit            m_ovf    = 1'b0;
   bit            m_pop;
   bit            m_ovf_set;
   bit            log_en   = 1'b0;
   logic [DW-1:0] drain_log[$];

   function automatic logic [DW-1:0] gold(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return a & ~b;
      endcase
   endfunction

   function automatic res_entry_t mk(input logic [DW-1:0] d, input logic [2:0] op);
      res_entry_t e;
      e.op   = op_e'(op);
      e.data = d;
`ifdef LOGIC_OP_PARITY_EN
      e.par  = ^d;
`endif
      return e;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op, input logic [DW-1:0] exp);
      data1   = a;
      data2   = b;
      op_sel  = op;
      data_en = 1'b1;
      exp_in.push_back(mk(exp, op));
      @(posedge clk);
      #1;
      data_en = 1'b0;
   endtask

   task automatic sendg(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op);
      send(a, b, op, gold(a, b, op));
   endtask

   task automatic wait_empty();
      int n = 0;
      out_ready = 1'b1;
      while ((out_valid || model_q.size() != 0 || m_s1_vld) && n < 40) begin
         cyc(1);
         n++;
      end
      chk("drain_empty", 32'(out_valid), 32'(0));
   endtask

   // Scoreboard: compare DUT against the queue model, then advance the model one edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", 32'(out_valid), 32'(0));
         chk("rst_cnt",   32'(fifo_cnt),  32'(0));
         chk("rst_ovf",   32'(ovf_err),   32'(0));
         chk("rst_data",  32'(out_data),  32'(0));
         chk("rst_op",    32'(out_op),    32'(0));
         model_q.delete();
         exp_in.delete();
         m_s1_vld = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         chk("valid", 32'(out_valid), 32'(model_q.size() != 0));
         chk("cnt",   32'(fifo_cnt),  32'(model_q.size()));
         chk("ovf",   32'(ovf_err),   32'(m_ovf));
         if (model_q.size() != 0) begin
            chk("data", 32'(out_data), 32'(model_q[0].data));
            chk("op",   32'(out_op),   32'(model_q[0].op));
`ifdef LOGIC_OP_PARITY_EN
            chk("par",  32'(out_par),  32'(model_q[0].par));
`endif
         end
         if (log_en && out_valid && out_ready) drain_log.push_back(out_data);
         m_pop     = out_ready && (model_q.size() != 0);
         m_ovf_set = 1'b0;
         if (m_pop) void'(model_q.pop_front());
         if (m_s1_vld) begin
            if (model_q.size() < DEPTH) model_q.push_back(m_s1);
            else m_ovf_set = 1'b1;
         end
         m_ovf    = m_ovf_set | (m_ovf & !err_clr);
         m_s1_vld = data_en;
         if (data_en) begin
            if (exp_in.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exp_queue: got empty expected entry at %0t", $time);
            end else begin
               m_s1 = exp_in.pop_front();
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{4'hC, 4'hA, 3'd0, 4'h8};
      tbl[1] = '{4'hC, 4'hA, 3'd1, 4'hE};
      tbl[2] = '{4'hC, 4'hA, 3'd2, 4'h6};
      tbl[3] = '{4'hC, 4'hA, 3'd3, 4'h7};
      tbl[4] = '{4'hC, 4'hA, 3'd4, 4'h1};
      tbl[5] = '{4'hC, 4'hA, 3'd5, 4'h9};
      tbl[6] = '{4'hC, 4'hA, 3'd6, 4'h3};
      tbl[7] = '{4'hC, 4'hA, 3'd7, 4'h4};

      rst_n     = 1'b0;
      data1     = '0;
      data2     = '0;
      data_en   = 1'b0;
      op_sel    = '0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      #6;
      chk("reset_valid", 32'(out_valid), 32'(0));
      chk("reset_cnt",   32'(fifo_cnt),  32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(2);

      // Single XOR: visible after the second edge
      out_ready = 1'b1;
      send(4'hC, 4'hA, 3'd2, 4'h6);
      chk("lat_early_valid", 32'(out_valid), 32'(0));
      cyc(1);
      chk("lat_valid", 32'(out_valid), 32'(1));
      chk("lat_data",  32'(out_data),  32'(4'h6));
      chk("lat_op",    32'(out_op),    32'(2));
      cyc(2);
      chk("lat_drained", 32'(out_valid), 32'(0));

      // Op sweep back-to-back, results must stream without gaps
      fork
         begin
            for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
         end
         begin
            @(posedge clk);
            for (int i = 0; i < 8; i++) begin
               @(posedge clk);
               #1;
               chk("sweep_valid", 32'(out_valid), 32'(1));
               chk("sweep_data",  32'(out_data),  32'(tbl[i].exp));
               chk("sweep_op",    32'(out_op),    32'(tbl[i].op));
            end
         end
      join
      cyc(3);

      // Overflow: fifth push dropped, sticky flag, clear precedence
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) sendg(4'(i + 1), 4'h0, 3'd1);
      cyc(2);
      chk("ovf_cnt",  32'(fifo_cnt), 32'(4));
      chk("ovf_flag", 32'(ovf_err),  32'(1));
      chk("ovf_head", 32'(out_data), 32'(1));
      sendg(4'h6, 4'h0, 3'd1);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("ovf_clr_coincide", 32'(ovf_err), 32'(1));
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("ovf_cleared", 32'(ovf_err), 32'(0));
      drain_log.delete();
      log_en = 1'b1;
      wait_empty();
      log_en = 1'b0;
      chk("drain_count", 32'(drain_log.size()), 32'(4));
      for (int i = 0; i < 4 && i < drain_log.size(); i++)
         chk("drain_data", 32'(drain_log[i]), 32'(i + 1));

      // Full FIFO with simultaneous push and pop every cycle
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) sendg(4'(i), 4'hA, 3'(i));
      chk("full_fill_cnt", 32'(fifo_cnt), 32'(4));
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sendg(4'(i + 5), 4'h3, 3'(i));
         chk("full_cnt", 32'(fifo_cnt), 32'(4));
      end
      chk("full_no_ovf", 32'(ovf_err), 32'(0));
      wait_empty();

      // Asynchronous reset between edges with results pending
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) sendg(4'(i + 9), 4'h5, 3'd2);
      chk("pre_rst_cnt", 32'(fifo_cnt), 32'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 32'(0));
      chk("async_cnt",   32'(fifo_cnt),  32'(0));
      chk("async_data",  32'(out_data),  32'(0));
      chk("async_op",    32'(out_op),    32'(0));
      cyc(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cyc(4);
      chk("no_stale", 32'(out_valid), 32'(0));

`ifdef LOGIC_OP_PARITY_EN
      out_ready = 1'b0;
      sendg(4'hC, 4'hA, 3'd3);
      sendg(4'hC, 4'hA, 3'd2);
      cyc(1);
      chk("par_7", 32'(out_par), 32'(1));
      out_ready = 1'b1;
      cyc(1);
      chk("par_6", 32'(out_par), 32'(0));
      wait_empty();
`endif

      // Random traffic with random backpressure and clears
      for (int n = 0; n < 300; n++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 2) != 0)
            sendg(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
         else
            cyc(1);
      end
      err_clr = 1'b0;
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
